// File: rtl/div16x8_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// A zero divisor short-circuits straight to DONE with an all-ones quotient.
module div16x8_seq #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  sclr,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [DIVIDEND_W-1:0] dvd_sr;
  logic [DIVIDEND_W-2:0] quo_sr;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W:0]    prem;
  logic [DIVISOR_W:0]    prem_nxt;
  logic [DIVISOR_W+1:0]  trial;
  logic [DIVISOR_W+1:0]  dvs_ext;
  logic [CNT_W-1:0]      cnt;
  logic                  qbit;
  logic                  accept;
  logic                  last_step;

  // Trial is formed one bit wider than prem so every prem bit participates;
  // prem[DIVISOR_W] stays 0 because prem < divisor after every step.
  always_comb begin
    accept    = (state == IDLE) && start;
    last_step = (state == CALC) && (cnt == LAST_CNT);
    trial     = {prem, dvd_sr[DIVIDEND_W-1]};
    dvs_ext   = (DIVISOR_W + 2)'(dvs);
    qbit      = 1'b0;
    prem_nxt  = trial[DIVISOR_W:0];
    if (trial >= dvs_ext) begin
      qbit     = 1'b1;
      prem_nxt = (DIVISOR_W + 1)'(trial - dvs_ext);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == LAST_CNT) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      dvd_sr    <= '0;
      quo_sr    <= '0;
      dvs       <= '0;
      prem      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      dvd_sr <= dividend;
      dvs    <= divisor;
      quo_sr <= '0;
      prem   <= '0;
      cnt    <= '0;
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= '0;
        div_zero  <= 1'b1;
      end
    end else if (state == CALC) begin
      prem   <= prem_nxt;
      dvd_sr <= {dvd_sr[DIVIDEND_W-2:0], 1'b0};
      quo_sr <= {quo_sr[DIVIDEND_W-3:0], qbit};
      cnt    <= cnt + 1'b1;
      if (last_step) begin
        quotient  <= {quo_sr, qbit};
        remainder <= prem_nxt[DIVISOR_W-1:0];
        div_zero  <= 1'b0;
      end
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_div16x8_seq.sv
// Scoreboard bench for div16x8_seq: expected results come from plain / and %.
module tb_div16x8_seq;

  logic        clk = 1'b0;
  logic        sclr;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   n_issued = 0;
  int   n_dropped = 0;
  int   lat;

  div16x8_seq #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
    .clk(clk), .sclr(sclr), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 8'd0) begin
      e.q  = 16'hFFFF;
      e.r  = 8'd0;
      e.dz = 1'b1;
    end else begin
      e.q  = a / {8'd0, b};
      e.r  = 8'(a % {8'd0, b});
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(mon_e.q));
        check("remainder", 32'(remainder), 32'(mon_e.r));
        check("div_zero", 32'(div_zero), 32'(mon_e.dz));
        check("busy_with_done", 32'(busy), 32'd0);
      end
    end
  end

  // Called #1 after an edge with the DUT idle; returns #1 after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    n_issued++;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_done(input int exp_lat, input bit zero, input bit step_out, output int l);
    l = -1;
    check("busy_after_accept", 32'(busy), zero ? 32'd0 : 32'd1);
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (done) begin
        l = k;
        break;
      end
    end
    if (zero) check("zero_latency", 32'(l == 0 || l == 1), 32'd1);
    else      check("done_latency", 32'(l), 32'(exp_lat));
    if (step_out) begin
      @(posedge clk);
      #1;
      check("done_pulse_width", 32'(done), 32'd0);
    end
  endtask

  initial begin
    sclr     = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    sclr = 1'b0;
    @(posedge clk);
    #1;

    issue(16'd1000, 8'd7);
    wait_done(16, 1'b0, 1'b1, lat);
    issue(16'hFFFF, 8'hFF);
    wait_done(16, 1'b0, 1'b1, lat);
    issue(16'd5, 8'd10);
    wait_done(16, 1'b0, 1'b1, lat);

    issue(16'h1234, 8'd0);
    wait_done(0, 1'b1, 1'b1, lat);
    issue(16'd100, 8'd3);
    wait_done(16, 1'b0, 1'b1, lat);

    // start re-pulsed mid-CALC with other operands must be ignored
    issue(16'd1000, 8'd7);
    repeat (4) @(posedge clk);
    #1;
    dividend = 16'd9;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'd4321;
    divisor  = 8'd55;
    wait_done(11, 1'b0, 1'b1, lat);
    repeat (5) @(posedge clk);
    #1;
    check("persist_quotient", 32'(quotient), 32'd142);
    check("persist_remainder", 32'(remainder), 32'd6);

    // sclr mid-CALC discards the operation
    issue(16'd1000, 8'd7);
    repeat (7) @(posedge clk);
    #1;
    sclr = 1'b1;
    @(posedge clk);
    #1;
    sclr = 1'b0;
    sb.delete();
    n_dropped++;
    check("sclr_busy", 32'(busy), 32'd0);
    check("sclr_done", 32'(done), 32'd0);
    check("sclr_quotient", 32'(quotient), 32'd0);
    check("sclr_remainder", 32'(remainder), 32'd0);
    check("sclr_div_zero", 32'(div_zero), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    issue(16'd200, 8'd9);
    wait_done(16, 1'b0, 1'b1, lat);

    // start held through the DONE cycle and the following IDLE cycle
    issue(16'd500, 8'd4);
    wait_done(16, 1'b0, 1'b0, lat);
    dividend = 16'd777;
    divisor  = 8'd13;
    start    = 1'b1;
    sb.push_back(model(16'd777, 8'd13));
    n_issued++;
    @(posedge clk);
    #1;
    check("b2b_busy_in_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(16, 1'b0, 1'b1, lat);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      int unsigned mode;
      mode = $urandom_range(0, 9);
      b    = 8'($urandom);
      if (mode < 4) begin
        if (b == 8'd0) b = 8'd1;
        a = 16'($urandom_range(0, 255)) * {8'd0, b};
      end else if (mode == 9) begin
        a = 16'($urandom);
        b = 8'd0;
      end else begin
        a = 16'($urandom);
      end
      issue(a, b);
      wait_done(16, b == 8'd0, 1'b1, lat);
    end

    repeat (5) @(posedge clk);
    #1;
    check("done_count", 32'(n_done), 32'(n_issued - n_dropped));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
